// File: rtl/nw_pkg.sv
// Shared types and default widths for the job scheduler and its arbiter.
// Holds the FSM state encoding and the default character/score widths.
package nw_pkg;

    localparam int NW_LENGTH = 10;
    localparam int NW_CWIDTH = 2;
    localparam int NW_SWIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/nw_rr_arb2.sv
// Two-way round-robin arbiter: purely combinational, one-hot or zero grant.
// On contention the requester that did not win last time is chosen.
module nw_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[0] && req[1]) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/nw_job_scheduler.sv
// Feeds one string-pair job at a time to an alignment grid; grant to result in CLEAR_CYCLES+2 min.
// Results wait in DONE until res_ready; no new grant while a job is in flight or unconsumed.
module nw_job_scheduler
    import nw_pkg::*;
#(
    parameter int LENGTH       = NW_LENGTH,
    parameter int CWIDTH       = NW_CWIDTH,
    parameter int SWIDTH       = NW_SWIDTH,
    parameter int CLEAR_CYCLES = 2,
    parameter int TIMEOUT      = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [2*LENGTH*CWIDTH-1:0] req_s1,
    input  logic [2*LENGTH*CWIDTH-1:0] req_s2,
    output logic                       grid_reset,
    output logic [LENGTH*CWIDTH-1:0]   grid_s1,
    output logic [LENGTH*CWIDTH-1:0]   grid_s2,
    input  logic signed [SWIDTH-1:0]   grid_score,
    input  logic                       grid_valid,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic signed [SWIDTH-1:0]   res_score,
    output logic                       res_id,
    output logic                       res_timeout
);

    localparam int SW = LENGTH * CWIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam logic [3:0]    CMAX = 4'(CLEAR_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    grant;
    logic          last_grant;
    logic [3:0]    clr_cnt;
    logic [TW-1:0] cnt;

    nw_rr_arb2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 2'b00;
        grid_reset = 1'b0;
        res_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = grant;
                if (|grant) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                grid_reset = 1'b1;
                if (clr_cnt == CMAX) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (grid_valid || (cnt == TMAX)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Reset overrides the handshake outputs and holds the grid cleared.
        if (reset) begin
            req_ready  = 2'b00;
            grid_reset = 1'b1;
            res_valid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt     <= '0;
            cnt         <= '0;
            last_grant  <= 1'b1;
            grid_s1     <= '0;
            grid_s2     <= '0;
            res_score   <= '0;
            res_id      <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        grid_s1 <= req_s1[grant[1]*SW +: SW];
                        grid_s2 <= req_s2[grant[1]*SW +: SW];
                        res_id  <= grant[1];
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 4'd1;
                    cnt     <= '0;
                end
                ST_RUN: begin
                    // A score arriving on the timeout cycle still counts as a result.
                    if (grid_valid) begin
                        res_score   <= grid_score;
                        res_timeout <= 1'b0;
                    end else if (cnt == TMAX) begin
                        res_score   <= '0;
                        res_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                ST_DONE: begin
                    if (res_ready) last_grant <= res_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nw_job_scheduler.sv
// Directed bench for nw_job_scheduler with CLEAR_CYCLES=2 and TIMEOUT=8.
module tb_nw_job_scheduler;

    localparam int SW = 20;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [2*SW-1:0]      req_s1;
    logic [2*SW-1:0]      req_s2;
    logic                 grid_reset;
    logic [SW-1:0]        grid_s1;
    logic [SW-1:0]        grid_s2;
    logic signed [15:0]   grid_score;
    logic                 grid_valid;
    logic                 res_valid;
    logic                 res_ready;
    logic signed [15:0]   res_score;
    logic                 res_id;
    logic                 res_timeout;

    int errors = 0;
    int checks = 0;

    localparam logic [SW-1:0] S1_R0 = 20'hA5A5A;
    localparam logic [SW-1:0] S1_R1 = 20'h0F0F1;
    localparam logic [SW-1:0] S2_R0 = 20'h12345;
    localparam logic [SW-1:0] S2_R1 = 20'hFEDCB;

    nw_job_scheduler #(
        .LENGTH(10), .CWIDTH(2), .SWIDTH(16), .CLEAR_CYCLES(2), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_s1(req_s1), .req_s2(req_s2),
        .grid_reset(grid_reset), .grid_s1(grid_s1), .grid_s2(grid_s2),
        .grid_score(grid_score), .grid_valid(grid_valid),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_score(res_score), .res_id(res_id), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 2'b01; res_ready = 1'b0;
        grid_valid = 1'b0; grid_score = '0;
        req_s1 = {S1_R1, S1_R0}; req_s2 = {S2_R1, S2_R0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
            checks++; if (grid_reset !== 1'b1) begin errors++; $display("FAIL rst_grid_reset: got %b want 1", grid_reset); end
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
            next_cycle();
        end
        reset = 1'b0; req_valid = 2'b00;
        @(negedge clk);
        checks++; if (grid_reset !== 1'b0) begin errors++; $display("FAIL idle_grid_reset: got %b want 0", grid_reset); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL idle_res_valid: got %b want 0", res_valid); end
        checks++; if (res_score !== 16'sd0) begin errors++; $display("FAIL rst_res_score: got %0d want 0", res_score); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL rst_res_id: got %b want 0", res_id); end
        checks++; if (res_timeout !== 1'b0) begin errors++; $display("FAIL rst_res_timeout: got %b want 0", res_timeout); end
        checks++; if (grid_s1 !== '0) begin errors++; $display("FAIL rst_grid_s1: got %h want 0", grid_s1); end
        checks++; if (grid_s2 !== '0) begin errors++; $display("FAIL rst_grid_s2: got %h want 0", grid_s2); end
        next_cycle();
    endtask

    task automatic test_single();
        req_valid = 2'b01;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", req_ready); end
        next_cycle();
        req_valid = 2'b00;
        req_s1 = ~{S1_R1, S1_R0}; req_s2 = ~{S2_R1, S2_R0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (grid_reset !== 1'b1) begin errors++; $display("FAIL single_clear%0d: grid_reset got %b want 1", i, grid_reset); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL single_clear_rdy%0d: got %b want 00", i, req_ready); end
            next_cycle();
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (grid_reset !== 1'b0) begin errors++; $display("FAIL single_run%0d: grid_reset got %b want 0", i, grid_reset); end
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_run_vld%0d: got %b want 0", i, res_valid); end
            checks++; if (grid_s1 !== S1_R0) begin errors++; $display("FAIL single_hold_s1: got %h want %h", grid_s1, S1_R0); end
            checks++; if (grid_s2 !== S2_R0) begin errors++; $display("FAIL single_hold_s2: got %h want %h", grid_s2, S2_R0); end
            next_cycle();
        end
        grid_valid = 1'b1; grid_score = 16'sd7;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_pre_done: res_valid got %b want 0", res_valid); end
        next_cycle();
        grid_valid = 1'b0; grid_score = 16'sd99; res_ready = 1'b1;
        @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_res_valid: got %b want 1", res_valid); end
        checks++; if (res_score !== 16'sd7) begin errors++; $display("FAIL single_res_score: got %0d want 7", res_score); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL single_res_id: got %b want 0", res_id); end
        checks++; if (res_timeout !== 1'b0) begin errors++; $display("FAIL single_res_timeout: got %b want 0", res_timeout); end
        next_cycle();
        res_ready = 1'b0;
        req_s1 = {S1_R1, S1_R0}; req_s2 = {S2_R1, S2_R0};
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_after: res_valid got %b want 0", res_valid); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_grant [3];
        logic [1:0] exp_rdy;
        logic       exp_vld;
        logic signed [15:0] exp_score;
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01;
        exp_score = -16'sd5;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        req_valid = 2'b11; grid_valid = 1'b1; grid_score = -16'sd5; res_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            exp_rdy = (c % 5 == 0) ? exp_grant[c / 5] : 2'b00;
            exp_vld = (c % 5 == 4);
            @(negedge clk);
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready, exp_rdy); end
            checks++; if (res_valid !== exp_vld) begin errors++; $display("FAIL rr_res_valid c%0d: got %b want %b", c, res_valid, exp_vld); end
            if (exp_vld) begin
                checks++; if (res_id !== exp_grant[c / 5][1]) begin errors++; $display("FAIL rr_res_id c%0d: got %b want %b", c, res_id, exp_grant[c / 5][1]); end
                checks++; if (res_score !== exp_score) begin errors++; $display("FAIL rr_res_score c%0d: got %0d want -5", c, res_score); end
            end
            next_cycle();
        end
        req_valid = 2'b00; grid_valid = 1'b0; res_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int lat;
        req_valid = 2'b10;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL to_grant: got %b want 10", req_ready); end
        next_cycle();
        req_valid = 2'b00;
        lat = 1;
        while (lat < 40) begin
            @(negedge clk);
            if (res_valid === 1'b1) break;
            next_cycle();
            lat++;
        end
        checks++; if (lat !== 12) begin errors++; $display("FAIL to_latency: got %0d want 12", lat); end
        checks++; if (res_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", res_timeout); end
        checks++; if (res_score !== 16'sd0) begin errors++; $display("FAIL to_score: got %0d want 0", res_score); end
        checks++; if (res_id !== 1'b1) begin errors++; $display("FAIL to_id: got %b want 1", res_id); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        req_valid = 2'b11; res_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b want 1", i, res_valid); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d: got %b want 00", i, req_ready); end
            checks++; if ({res_id, res_timeout, res_score} !== {1'b1, 1'b1, 16'sd0}) begin
                errors++; $display("FAIL bp_hold%0d: id=%b to=%b score=%0d want id=1 to=1 score=0", i, res_id, res_timeout, res_score);
            end
            next_cycle();
        end
        res_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_handshake_ready: got %b want 00", req_ready); end
        next_cycle();
        res_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_next_grant: got %b want 01", req_ready); end
        next_cycle();
        req_valid = 2'b00;
    endtask

    task automatic test_reset_run();
        for (int i = 0; i < 4; i++) next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (grid_reset !== 1'b1) begin errors++; $display("FAIL rr_mid_grid_reset: got %b want 1", grid_reset); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rr_mid_res_valid: got %b want 0", res_valid); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rr_mid_req_ready: got %b want 00", req_ready); end
        next_cycle();
        reset = 1'b0; req_valid = 2'b11;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_regrant: got %b want 01", req_ready); end
        checks++; if (grid_s1 !== '0) begin errors++; $display("FAIL rr_cleared_s1: got %h want 0", grid_s1); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rr_post_res_valid: got %b want 0", res_valid); end
        next_cycle();
        req_valid = 2'b00;
    endtask

    task automatic test_tie();
        logic signed [15:0] exp_score;
        exp_score = -16'sd3;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) begin
                grid_valid = 1'b1; grid_score = -16'sd3;
            end
            @(negedge clk);
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL tie_wait%0d: res_valid got %b want 0", k, res_valid); end
            next_cycle();
        end
        grid_valid = 1'b0; grid_score = 16'sd0;
        @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL tie_valid: got %b want 1", res_valid); end
        checks++; if (res_score !== exp_score) begin errors++; $display("FAIL tie_score: got %0d want -3", res_score); end
        checks++; if (res_timeout !== 1'b0) begin errors++; $display("FAIL tie_timeout: got %b want 0", res_timeout); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL tie_id: got %b want 0", res_id); end
        checks++; if (grid_s2 !== S2_R0) begin errors++; $display("FAIL tie_s2: got %h want %h", grid_s2, S2_R0); end
        res_ready = 1'b1;
        next_cycle();
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_backpressure();
        test_reset_run();
        test_tie();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
